// File: rtl/mem_responder.sv
// Word-addressed unified memory with a Req/Ready handshake and fixed access latency.
// Misaligned or out-of-range accesses complete normally but are flagged on AdrErr.
module mem_responder #(
   parameter int    ADDR_W    = 6,
   parameter int    LATENCY   = 2,
   parameter string INIT_FILE = "memfile.dat"
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic        MemWrite,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        Busy,
   output logic        AdrErr
);

   localparam int DEPTH = 2 ** ADDR_W;

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mem_responder: LATENCY must be in 1..15");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state, w_next;
   logic [3:0]  r_cnt, w_cnt_next;
   logic        r_we, r_err;
   logic [31:0] r_adr, r_wdata, r_rdata;
   logic [31:0] r_mem [0:DEPTH-1];

   logic              w_accept, w_enter_done, w_op_we, w_err;
   logic [31:0]       w_op_adr, w_op_wdata;
   logic [ADDR_W-1:0] w_idx;

   // The counter reaches zero on the edge that enters DONE, so WAIT lasts LATENCY-1
   // cycles and LATENCY=1 goes straight from acceptance to DONE.
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_accept   = 1'b0;
      case (r_state)
         S_IDLE: w_accept = Req;
         S_WAIT: begin
            w_cnt_next = r_cnt - 4'd1;
            if (w_cnt_next == 4'd0) w_next = S_DONE;
         end
         S_DONE: begin
            w_accept = Req;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (w_accept) begin
         w_cnt_next = 4'(LATENCY - 1);
         w_next     = (w_cnt_next == 4'd0) ? S_DONE : S_WAIT;
      end
   end

   assign w_enter_done = (w_next == S_DONE) && ((r_state == S_WAIT) || w_accept);

   // With LATENCY=1 the access commits on its acceptance edge, so use the live inputs.
   assign w_op_adr   = w_accept ? Adr       : r_adr;
   assign w_op_wdata = w_accept ? WriteData : r_wdata;
   assign w_op_we    = w_accept ? MemWrite  : r_we;
   assign w_idx      = w_op_adr[ADDR_W+1:2];
   assign w_err      = (w_op_adr[1:0] != 2'b00) || (w_op_adr[31:ADDR_W+2] != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_adr   <= 32'h0;
         r_wdata <= 32'h0;
         r_rdata <= 32'h0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_adr   <= Adr;
            r_wdata <= WriteData;
            r_we    <= MemWrite;
         end
         if (w_enter_done) begin
            r_err <= w_err;
            if (!w_op_we) r_rdata <= w_err ? 32'hDEADBEEF : r_mem[w_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_enter_done && w_op_we && !w_err) r_mem[w_idx] <= w_op_wdata;
   end

   assign Ready    = (r_state == S_DONE);
   assign Busy     = (r_state != S_IDLE);
   assign AdrErr   = Ready && r_err;
   assign ReadData = r_rdata;

endmodule
